dma_ring_sm: RTL and testbench
==============================

DMA_RING_SM -- requirements
Module: dma_ring_sm

Interface
REQ-001 SHALL have parameter NUM_BUF, default 8, ring depth in buffers (2..16).
REQ-002 SHALL have parameter TLP_DW, default 32, DWORDs per TLP (address step).
REQ-003 SHALL have parameter CNT_W, default 25, width of per-buffer TLP count.
REQ-004 SHALL derive localparam BUF_W = clog2(NUM_BUF).
REQ-005 trn_clk  in  1  sole clock, all logic on rising edge.
REQ-006 pio_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 stream_on  in  1  acquisition enable; low requests stop.
REQ-008 dma_ready  in  1  source FIFO holds one full TLP.
REQ-009 dma_rd_en  in  1  TX engine reading payload; high for the whole TLP.
REQ-010 dma_init_addr  in  30  ring base address, [31:2] DW units.
REQ-011 dma_size  in  CNT_W  TLPs per buffer.
REQ-012 host_ack  in  1  one-cycle pulse: host released one buffer.
REQ-013 dma_addr  out  30  current TLP address, [31:2].
REQ-014 dma_start_o  out  1  TLP request to TX engine.
REQ-015 irq_dma_o  out  1  one-cycle buffer-complete pulse.
REQ-016 dma_curr_buf  out  BUF_W  index of buffer being filled.
REQ-017 buf_fill  out  BUF_W+1  completed buffers not yet acknowledged.
REQ-018 overrun_o  out  1  sticky: data ready while ring full.

Function
REQ-019 SHALL implement states IDLE, REQ, XFER, NEXT, DONE, STALL, one-hot, with unreachable encodings recovering to IDLE.
REQ-020 IDLE: with stream_on=1, dma_size!=0, buf_fill<NUM_BUF and dma_ready=1, SHALL latch dma_size into the packet counter, set dma_start_o=1 next cycle, and go to REQ.
REQ-021 IDLE with buf_fill==NUM_BUF and stream_on=1 SHALL go to STALL.
REQ-022 dma_size==0 SHALL hold IDLE with no requests.
REQ-023 REQ: on dma_rd_en=1, SHALL clear dma_start_o and go to XFER.
REQ-024 XFER: on dma_rd_en=0, SHALL decrement the packet counter, add TLP_DW to dma_addr (mod 2^30), and go to NEXT.
REQ-025 NEXT: counter!=0 and stream_on=1 and dma_ready=1 -> dma_start_o=1, REQ; counter!=0 and dma_ready=0 -> stay; counter==0 -> DONE.
REQ-026 DONE (one cycle): SHALL pulse irq_dma_o, increment buf_fill, advance dma_curr_buf; if dma_curr_buf was NUM_BUF-1, SHALL wrap it to 0 and reload dma_addr from dma_init_addr; go to IDLE.
REQ-027 STALL: no requests; SHALL set overrun_o when dma_ready=1; return to IDLE once buf_fill<NUM_BUF.
REQ-028 host_ack SHALL decrement buf_fill when nonzero; at zero it SHALL be ignored; host_ack coinciding with the DONE increment SHALL leave buf_fill unchanged.
REQ-029 stream_on=0 in IDLE, NEXT or STALL SHALL, next cycle, go to IDLE, clear dma_start_o, dma_curr_buf, buf_fill and overrun_o, and load dma_addr from dma_init_addr.
REQ-030 stream_on=0 in REQ or XFER SHALL finish the current TLP (wait for dma_rd_en fall), then perform REQ-029; no irq issued.
REQ-031 While stream_on=0, dma_addr SHALL track dma_init_addr.

Reset
REQ-032 pio_reset_n=0 SHALL asynchronously force IDLE, dma_start_o=0, irq_dma_o=0, dma_curr_buf=0, buf_fill=0, overrun_o=0, dma_addr=0, packet counter=0.
REQ-033 Reset release SHALL take effect on the next trn_clk rising edge; no output shall glitch high on release.

Structure
REQ-034 State encodings and default TLP_DW (DMA_TLP_SIZE) SHALL live in the shared ADC_DAQ package.
REQ-035 Buffer-occupancy counter (inc/dec/simultaneous logic) SHALL be a sub-module named dma_buf_occ.

Verification
REQ-036 NUM_BUF=4, dma_size=2, base 0x100, dma_ready=1, host_ack after each irq -> 8 TLPs at 0x100,0x120..0x1E0, then addr 0x100, buf 0; four irq pulses.
REQ-037 No host_ack, NUM_BUF=4, dma_size=1 -> four irqs, buf_fill=4, STALL, overrun_o=1; one host_ack -> resumes, overrun_o stays 1.
REQ-038 host_ack on the DONE cycle with buf_fill=2 -> buf_fill stays 2.
REQ-039 stream_on dropped mid-XFER -> dma_rd_en fall completes TLP, then IDLE, buf_fill=0, no irq.
REQ-040 pio_reset_n asserted in REQ -> dma_start_o=0 immediately without clock; after release, restart from dma_init_addr.
REQ-041 dma_size=0 with dma_ready=1 for 100 cycles -> dma_start_o never asserted.

Source files
------------

// File: rtl/adc_daq_pkg.sv
// Shared ADC_DAQ definitions: DMA sequencer state encodings and the default TLP size.
package adc_daq_pkg;

  localparam int DMA_TLP_SIZE = 32;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_REQ   = 6'b000010,
    ST_XFER  = 6'b000100,
    ST_NEXT  = 6'b001000,
    ST_DONE  = 6'b010000,
    ST_STALL = 6'b100000
  } dma_state_e;

endpackage

// File: rtl/dma_buf_occ.sv
// Ring occupancy counter: completed buffers the host has not yet released.
module dma_buf_occ #(
  parameter  int NUM_BUF = 8,
  localparam int BUF_W   = $clog2(NUM_BUF)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           inc_i,
  input  logic           dec_i,
  output logic [BUF_W:0] fill_o
);

  localparam logic [BUF_W:0] FULL_LVL = (BUF_W+1)'(NUM_BUF);

  logic [BUF_W:0] fill_q, fill_d;
  logic           dec_ok;

  // An ack against an empty ring is dropped; a coinciding inc/dec cancels out.
  always_comb begin
    dec_ok = dec_i && (fill_q != '0);
    fill_d = fill_q;
    if (clr_i) begin
      fill_d = '0;
    end else if (inc_i && !dec_ok) begin
      if (fill_q != FULL_LVL) fill_d = fill_q + 1'b1;
    end else if (dec_ok && !inc_i) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/dma_ring_sm.sv
// DMA ring sequencer: requests TLPs buffer by buffer around a NUM_BUF-deep host ring,
// raising one interrupt per filled buffer and stalling while the host holds every buffer.
module dma_ring_sm
  import adc_daq_pkg::*;
#(
  parameter  int NUM_BUF = 8,
  parameter  int TLP_DW  = DMA_TLP_SIZE,
  parameter  int CNT_W   = 25,
  localparam int BUF_W   = $clog2(NUM_BUF)
) (
  input  logic             trn_clk,
  input  logic             pio_reset_n,
  input  logic             stream_on,
  input  logic             dma_ready,
  input  logic             dma_rd_en,
  input  logic [29:0]      dma_init_addr,
  input  logic [CNT_W-1:0] dma_size,
  input  logic             host_ack,
  output logic [29:0]      dma_addr,
  output logic             dma_start_o,
  output logic             irq_dma_o,
  output logic [BUF_W-1:0] dma_curr_buf,
  output logic [BUF_W:0]   buf_fill,
  output logic             overrun_o
);

  localparam logic [BUF_W:0]   FULL_LVL = (BUF_W+1)'(NUM_BUF);
  localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUF-1);

  dma_state_e       state_q, state_d;
  logic             start_q, start_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic [BUF_W-1:0] cbuf_q, cbuf_d;
  logic [29:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush, occ_inc, ring_full;

  assign ring_full = (buf_fill == FULL_LVL);

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    irq_d     = 1'b0;
    overrun_d = overrun_q;
    cbuf_d    = cbuf_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    flush     = 1'b0;
    occ_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!stream_on) begin
          flush = 1'b1;
        end else if (ring_full) begin
          state_d = ST_STALL;
        end else if ((dma_size != '0) && dma_ready) begin
          cnt_d   = dma_size;
          start_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dma_rd_en) begin
          start_d = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // A stop request is honoured only once the in-flight TLP has drained.
        if (!dma_rd_en) begin
          if (!stream_on) begin
            flush = 1'b1;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + 30'(TLP_DW);
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (!stream_on) begin
          flush = 1'b1;
        end else if (cnt_q == '0) begin
          irq_d   = 1'b1;
          state_d = ST_DONE;
        end else if (dma_ready) begin
          start_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        occ_inc = 1'b1;
        state_d = ST_IDLE;
        if (cbuf_q == LAST_BUF) begin
          cbuf_d = '0;
          addr_d = dma_init_addr;
        end else begin
          cbuf_d = cbuf_q + 1'b1;
        end
      end
      ST_STALL: begin
        if (!stream_on) begin
          flush = 1'b1;
        end else begin
          if (dma_ready) overrun_d = 1'b1;
          if (!ring_full) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d   = ST_IDLE;
      start_d   = 1'b0;
      cbuf_d    = '0;
      overrun_d = 1'b0;
      addr_d    = dma_init_addr;
    end
  end

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      cbuf_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      cbuf_q    <= cbuf_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

  dma_buf_occ #(
    .NUM_BUF (NUM_BUF)
  ) u_occ (
    .clk    (trn_clk),
    .rst_n  (pio_reset_n),
    .clr_i  (flush),
    .inc_i  (occ_inc),
    .dec_i  (host_ack),
    .fill_o (buf_fill)
  );

  assign dma_addr     = addr_q;
  assign dma_start_o  = start_q;
  assign irq_dma_o    = irq_q;
  assign dma_curr_buf = cbuf_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_dma_ring_sm.sv
// Directed-plus-random bench for dma_ring_sm: a TX-engine responder with random
// latency/length, and a ring model computing TLP addresses, occupancy and irq totals.
module tb_dma_ring_sm;

  localparam int NB  = 4;
  localparam int TLP = 32;
  localparam int CW  = 25;

  logic          trn_clk = 1'b0;
  logic          pio_reset_n;
  logic          stream_on, dma_ready, dma_rd_en, host_ack;
  logic [29:0]   dma_init_addr;
  logic [CW-1:0] dma_size;
  logic [29:0]   dma_addr;
  logic          dma_start_o, irq_dma_o, overrun_o;
  logic [1:0]    dma_curr_buf;
  logic [2:0]    buf_fill;

  int n_cmp = 0;
  int n_err = 0;
  int irq_cnt = 0;
  int irq_exp = 0;
  int fill_exp = 0;

  dma_ring_sm #(.NUM_BUF(NB), .TLP_DW(TLP), .CNT_W(CW)) dut (
    .trn_clk       (trn_clk),
    .pio_reset_n   (pio_reset_n),
    .stream_on     (stream_on),
    .dma_ready     (dma_ready),
    .dma_rd_en     (dma_rd_en),
    .dma_init_addr (dma_init_addr),
    .dma_size      (dma_size),
    .host_ack      (host_ack),
    .dma_addr      (dma_addr),
    .dma_start_o   (dma_start_o),
    .irq_dma_o     (irq_dma_o),
    .dma_curr_buf  (dma_curr_buf),
    .buf_fill      (buf_fill),
    .overrun_o     (overrun_o)
  );

  always #5 trn_clk = ~trn_clk;

  always @(negedge trn_clk) if (irq_dma_o === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ring model: TLP k of a session lands at base + TLP*(k mod ring length), mod 2^30.
  function automatic logic [29:0] ring_addr(input logic [29:0] base, input int k, input int sz);
    ring_addr = base + 30'(TLP * (k % (NB * sz)));
  endfunction

  task automatic tick();
    @(negedge trn_clk);
  endtask

  task automatic serve_tlp(input logic [29:0] exp_addr);
    int t;
    int lat;
    int len;
    t = 0;
    lat = $urandom_range(0, 3);
    len = $urandom_range(1, 4);
    while (dma_start_o !== 1'b1 && t < 100) begin tick(); t++; end
    chk("start_seen", {31'd0, dma_start_o}, 32'd1);
    if (dma_start_o !== 1'b1) return;
    chk("tlp_addr", {2'b0, dma_addr}, {2'b0, exp_addr});
    $display("TLP addr=0x%0h lat=%0d len=%0d buf=%0d", dma_addr, lat, len, dma_curr_buf);
    repeat (lat) tick();
    dma_rd_en = 1'b1;
    tick();
    chk("start_clear", {31'd0, dma_start_o}, 32'd0);
    repeat (len - 1) tick();
    dma_rd_en = 1'b0;
    tick();
  endtask

  // Returns one cycle after the irq pulse; optionally acks during the DONE cycle itself.
  task automatic wait_irq(input bit ack_on_done);
    int t;
    t = 0;
    while (irq_dma_o !== 1'b1 && t < 40) begin tick(); t++; end
    chk("irq_pulse", {31'd0, irq_dma_o}, 32'd1);
    irq_exp++;
    if (ack_on_done) host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    chk("irq_width", {31'd0, irq_dma_o}, 32'd0);
  endtask

  task automatic ack_one();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    if (fill_exp > 0) fill_exp--;
    chk("fill_after_ack", {29'd0, buf_fill}, 32'(fill_exp));
  endtask

  task automatic stop_stream();
    stream_on = 1'b0;
    tick();
    tick();
    fill_exp = 0;
  endtask

  initial begin
    logic [29:0] base;
    int          start_hits;
    int          irq_snap;

    pio_reset_n = 1'b0; stream_on = 1'b0; dma_ready = 1'b0; dma_rd_en = 1'b0;
    host_ack = 1'b0; dma_size = '0; base = 30'h100; dma_init_addr = base;

    // Reset state
    repeat (3) tick();
    chk("rst_start", {31'd0, dma_start_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_dma_o}, 32'd0);
    chk("rst_addr", {2'b0, dma_addr}, 32'd0);
    chk("rst_fill", {29'd0, buf_fill}, 32'd0);
    chk("rst_buf", {30'd0, dma_curr_buf}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
    pio_reset_n = 1'b1;
    tick();
    chk("rel_start", {31'd0, dma_start_o}, 32'd0);
    chk("idle_track", {2'b0, dma_addr}, {2'b0, base});
    dma_init_addr = 30'($urandom);
    tick();
    chk("idle_track_rnd", {2'b0, dma_addr}, {2'b0, dma_init_addr});
    dma_init_addr = base;
    tick();

    // Ring walk: size 2, ack every buffer except the last of six
    dma_size = 2; dma_ready = 1'b1; stream_on = 1'b1;
    for (int k = 0; k < 12; k++) begin
      serve_tlp(ring_addr(base, k, 2));
      if (k % 2 == 1) begin
        wait_irq(1'b0);
        fill_exp++;
        chk("walk_fill", {29'd0, buf_fill}, 32'(fill_exp));
        chk("walk_buf", {30'd0, dma_curr_buf}, 32'(((k + 1) / 2) % NB));
        chk("walk_addr", {2'b0, dma_addr}, {2'b0, ring_addr(base, k + 1, 2)});
        if (k != 11) ack_one();
      end
    end

    // Stop while a TLP is in flight: finish it, then flush with no irq
    irq_snap = irq_cnt;
    serve_tlp(ring_addr(base, 12, 2));
    chk("pre_stop_fill", {29'd0, buf_fill}, 32'd1);
    begin
      int t;
      t = 0;
      while (dma_start_o !== 1'b1 && t < 100) begin tick(); t++; end
    end
    dma_rd_en = 1'b1;
    tick();
    stream_on = 1'b0;
    tick(); tick();
    chk("stop_in_xfer_fill", {29'd0, buf_fill}, 32'd1);
    dma_rd_en = 1'b0;
    tick(); tick();
    fill_exp = 0;
    chk("stop_fill", {29'd0, buf_fill}, 32'd0);
    chk("stop_buf", {30'd0, dma_curr_buf}, 32'd0);
    chk("stop_addr", {2'b0, dma_addr}, {2'b0, base});
    chk("stop_start", {31'd0, dma_start_o}, 32'd0);
    repeat (4) tick();
    chk("stop_no_irq", 32'(irq_cnt), 32'(irq_snap));

    // Fill the ring with no acks, stall, overrun, then resume on one ack
    dma_size = 1; stream_on = 1'b1;
    for (int k = 0; k < NB; k++) begin
      serve_tlp(ring_addr(base, k, 1));
      wait_irq(1'b0);
      fill_exp++;
      chk("full_fill", {29'd0, buf_fill}, 32'(fill_exp));
    end
    start_hits = 0;
    repeat (6) begin tick(); if (dma_start_o === 1'b1) start_hits++; end
    chk("stall_no_req", 32'(start_hits), 32'd0);
    chk("stall_overrun", {31'd0, overrun_o}, 32'd1);
    ack_one();
    serve_tlp(ring_addr(base, NB, 1));
    chk("overrun_sticky", {31'd0, overrun_o}, 32'd1);
    wait_irq(1'b0);
    fill_exp++;
    chk("resume_fill", {29'd0, buf_fill}, 32'(fill_exp));
    stop_stream();
    chk("flush_overrun", {31'd0, overrun_o}, 32'd0);
    chk("flush_fill", {29'd0, buf_fill}, 32'd0);

    // Ack coinciding with the DONE increment at fill 2
    stream_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve_tlp(ring_addr(base, k, 1));
      wait_irq(k == 2);
      if (k != 2) fill_exp++;
      chk("coinc_fill", {29'd0, buf_fill}, 32'(fill_exp));
    end

    // Asynchronous reset while a request is pending
    begin
      int t;
      t = 0;
      while (dma_start_o !== 1'b1 && t < 100) begin tick(); t++; end
    end
    #2;
    pio_reset_n = 1'b0;
    stream_on = 1'b0;
    #1;
    chk("async_start", {31'd0, dma_start_o}, 32'd0);
    chk("async_fill", {29'd0, buf_fill}, 32'd0);
    chk("async_addr", {2'b0, dma_addr}, 32'd0);
    tick();
    pio_reset_n = 1'b1;
    fill_exp = 0;
    base = 30'h3FFFFFF0;
    dma_init_addr = base;
    tick();
    chk("rst_reload", {2'b0, dma_addr}, {2'b0, base});
    dma_size = 2; stream_on = 1'b1;
    for (int k = 0; k < 2; k++) serve_tlp(ring_addr(base, k, 2));
    wait_irq(1'b0);
    chk("wrap30_addr", {2'b0, dma_addr}, {2'b0, ring_addr(base, 2, 2)});
    chk("wrap30_buf", {30'd0, dma_curr_buf}, 32'd1);
    stop_stream();

    // Zero-length buffers never request
    irq_snap = irq_cnt;
    dma_size = '0; stream_on = 1'b1; dma_ready = 1'b1;
    start_hits = 0;
    repeat (100) begin tick(); if (dma_start_o === 1'b1) start_hits++; end
    chk("size0_no_req", 32'(start_hits), 32'd0);
    chk("size0_no_irq", 32'(irq_cnt), 32'(irq_snap));
    chk("irq_total", 32'(irq_cnt), 32'(irq_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
